// File: rtl/bp_me_burst_pump_out.sv
// Purpose: serialise FSM header+beats into outbound BedRock burst header/data channels.
// Latency: 1 cycle FSM accept -> msg valid (0 with BP_ME_BURST_PUMP_OUT_CUT_THROUGH_EN defined).
// Backpressure: a full header/data FIFO deasserts fsm_ready_and_o; nothing is dropped.
//
// Header layout (MSB..LSB): msg_type[3:0], size[2:0], addr[paddr_width_p-1:0], payload.
// Message size in bytes is (1 << size).

// Small generic FIFO used for both outbound channels.
module bp_me_burst_pump_out_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enq_v,
  input  logic [width_p-1:0] i_enq_dat,
  output logic               o_enq_rdy,
  output logic               o_deq_v,
  output logic [width_p-1:0] o_deq_dat,
  input  logic               i_deq_rdy
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr, r_rptr;
  logic [ptr_w_lp:0]   r_count;
  logic                w_push, w_pop;

  assign o_enq_rdy = (r_count != (ptr_w_lp+1)'(els_p));

`ifdef BP_ME_BURST_PUMP_OUT_CUT_THROUGH_EN
  // An empty FIFO passes the incoming beat straight through; it is only stored
  // when the consumer does not take it in the same cycle.
  logic w_empty;
  assign w_empty   = (r_count == '0);
  assign o_deq_v   = w_empty ? i_enq_v : 1'b1;
  assign o_deq_dat = w_empty ? i_enq_dat : r_mem[r_rptr];
  assign w_push    = i_enq_v & o_enq_rdy & ~(w_empty & i_deq_rdy);
  assign w_pop     = ~w_empty & i_deq_rdy;
`else
  assign o_deq_v   = (r_count != '0);
  assign o_deq_dat = r_mem[r_rptr];
  assign w_push    = i_enq_v & o_enq_rdy;
  assign w_pop     = o_deq_v & i_deq_rdy;
`endif

  // Storage write; contents need no reset since validity lives in r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_enq_dat;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == ptr_w_lp'(els_p-1)) ? '0 : r_wptr + ptr_w_lp'(1);
      if (w_pop)  r_rptr <= (r_rptr == ptr_w_lp'(els_p-1)) ? '0 : r_rptr + ptr_w_lp'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ptr_w_lp+1)'(1);
        2'b01:   r_count <= r_count - (ptr_w_lp+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module bp_me_burst_pump_out #(
  parameter int          paddr_width_p       = 40,
  parameter int          stream_data_width_p = 64,
  parameter int          block_width_p       = 512,
  parameter int          payload_width_p     = 8,
  parameter logic [15:0] msg_stream_mask_p   = '0,
  parameter logic [15:0] fsm_stream_mask_p   = msg_stream_mask_p,
  parameter int          header_els_p        = 2,
  parameter int          data_els_p          = 2,
  localparam int stream_bytes_lp      = stream_data_width_p / 8,
  localparam int stream_offset_lp     = $clog2(stream_bytes_lp),
  localparam int stream_words_lp      = block_width_p / stream_data_width_p,
  localparam int stream_cnt_width_lp  = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1,
  localparam int xce_header_width_lp  = 4 + 3 + paddr_width_p + payload_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [xce_header_width_lp-1:0] fsm_header_i,
  input  logic                           fsm_has_data_i,
  input  logic [stream_data_width_p-1:0] fsm_data_i,
  input  logic                           fsm_v_i,
  output logic                           fsm_ready_and_o,
  output logic [stream_cnt_width_lp-1:0] fsm_cnt_o,
  output logic                           fsm_new_o,
  output logic                           fsm_last_o,
  output logic [xce_header_width_lp-1:0] msg_header_o,
  output logic                           msg_header_v_o,
  input  logic                           msg_header_ready_and_i,
  output logic                           msg_has_data_o,
  output logic [stream_data_width_p-1:0] msg_data_o,
  output logic                           msg_data_v_o,
  input  logic                           msg_data_ready_and_i,
  output logic                           msg_last_o
);
  localparam int cw_lp = stream_cnt_width_lp;

  if ((block_width_p % stream_data_width_p) != 0 || block_width_p < stream_data_width_p) begin : g_param_err
    $error("bp_me_burst_pump_out: block width must be a non-zero multiple of stream width");
  end

  typedef enum logic {e_ready, e_stream} state_e;

  state_e             r_state;
  logic [cw_lp-1:0]   r_beat;   // beats of the current message already accepted
  logic [cw_lp-1:0]   r_cnt;    // wrapped word index of the next beat
  logic [3:0]         w_msg_type;
  logic [2:0]         w_msg_size;
  logic [cw_lp-1:0]   w_crit_word;
  logic               w_fsm_stream, w_msg_stream;
  logic [cw_lp-1:0]   w_fsm_last_idx;
  logic               w_data_enq, w_accept;
  logic               w_hdr_rdy, w_hdr_v, w_dat_rdy, w_dat_v;

  assign w_msg_type   = fsm_header_i[xce_header_width_lp-1 -: 4];
  assign w_msg_size   = fsm_header_i[xce_header_width_lp-5 -: 3];
  assign w_crit_word  = fsm_header_i[payload_width_p + stream_offset_lp +: cw_lp];
  assign w_fsm_stream = fsm_stream_mask_p[w_msg_type];
  assign w_msg_stream = msg_stream_mask_p[w_msg_type];

  function automatic logic [cw_lp-1:0] wrap_inc(input logic [cw_lp-1:0] c);
    return (c == cw_lp'(stream_words_lp-1)) ? '0 : c + cw_lp'(1);
  endfunction

  // Index of the final FSM beat: messages no wider than a beat, or non-streamed types, are one beat.
  always_comb begin
    w_fsm_last_idx = '0;
    if (w_fsm_stream && (int'(w_msg_size) > stream_offset_lp))
      w_fsm_last_idx = cw_lp'((1 << (int'(w_msg_size) - stream_offset_lp)) - 1);
  end

  assign fsm_new_o  = reset_i | (r_state == e_ready);
  assign fsm_last_o = (r_beat == w_fsm_last_idx);
  assign fsm_cnt_o  = reset_i ? '0 : (fsm_new_o ? w_crit_word : r_cnt);

  // Multi-beat msg types carry every beat; otherwise only the final FSM beat holds the data.
  assign w_data_enq      = fsm_has_data_i & (w_msg_stream | fsm_last_o);
  assign fsm_ready_and_o = ~reset_i & (~fsm_new_o | w_hdr_rdy) & (~w_data_enq | w_dat_rdy);
  assign w_accept        = fsm_v_i & fsm_ready_and_o;

  // Message sequencing: beat counter for first/last, word counter wrapping from the critical word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_ready;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      case (r_state)
        e_ready: begin
          if (!fsm_last_o) begin
            r_state <= e_stream;
            r_beat  <= cw_lp'(1);
            r_cnt   <= wrap_inc(w_crit_word);
          end
        end
        e_stream: begin
          r_cnt <= wrap_inc(r_cnt);
          if (fsm_last_o) begin
            r_state <= e_ready;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + cw_lp'(1);
          end
        end
        default: r_state <= e_ready;
      endcase
    end
  end

  // Streaming a single FSM beat into many msg beats is not supported.
  assert property (@(posedge clk_i) disable iff (reset_i) fsm_v_i |-> !(w_msg_stream && !w_fsm_stream));

  bp_me_burst_pump_out_fifo #(
    .width_p (xce_header_width_lp + 1),
    .els_p   (header_els_p)
  ) u_hdr_fifo (
    .i_clk     (clk_i),
    .i_reset   (reset_i),
    .i_enq_v   (w_accept & fsm_new_o),
    .i_enq_dat ({fsm_header_i, fsm_has_data_i}),
    .o_enq_rdy (w_hdr_rdy),
    .o_deq_v   (w_hdr_v),
    .o_deq_dat ({msg_header_o, msg_has_data_o}),
    .i_deq_rdy (msg_header_ready_and_i)
  );

  bp_me_burst_pump_out_fifo #(
    .width_p (stream_data_width_p + 1),
    .els_p   (data_els_p)
  ) u_dat_fifo (
    .i_clk     (clk_i),
    .i_reset   (reset_i),
    .i_enq_v   (w_accept & w_data_enq),
    .i_enq_dat ({fsm_data_i, fsm_last_o}),
    .o_enq_rdy (w_dat_rdy),
    .o_deq_v   (w_dat_v),
    .o_deq_dat ({msg_data_o, msg_last_o}),
    .i_deq_rdy (msg_data_ready_and_i)
  );

  assign msg_header_v_o = w_hdr_v & ~reset_i;
  assign msg_data_v_o   = w_dat_v & ~reset_i;
endmodule

// File: tb/tb_bp_me_burst_pump_out.sv
module tb_bp_me_burst_pump_out;
  localparam int          PADDR = 40;
  localparam int          SDW   = 64;
  localparam int          BLK   = 512;
  localparam int          PAY   = 8;
  localparam int          HW    = 4 + 3 + PADDR + PAY;
  localparam logic [15:0] MSG_MASK = 16'h0002;  // type 1: multi-beat on msg side
  localparam logic [15:0] FSM_MASK = 16'h0006;  // types 1,2: multi-beat on FSM side

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic [HW-1:0]   fsm_header_i = '0;
  logic            fsm_has_data_i = 1'b0;
  logic [SDW-1:0]  fsm_data_i = '0;
  logic            fsm_v_i = 1'b0;
  logic            fsm_ready_and_o;
  logic [2:0]      fsm_cnt_o;
  logic            fsm_new_o, fsm_last_o;
  logic [HW-1:0]   msg_header_o;
  logic            msg_header_v_o;
  logic            msg_header_ready_and_i = 1'b0;
  logic            msg_has_data_o;
  logic [SDW-1:0]  msg_data_o;
  logic            msg_data_v_o;
  logic            msg_data_ready_and_i = 1'b0;
  logic            msg_last_o;

  bp_me_burst_pump_out #(
    .paddr_width_p(PADDR), .stream_data_width_p(SDW), .block_width_p(BLK),
    .payload_width_p(PAY), .msg_stream_mask_p(MSG_MASK), .fsm_stream_mask_p(FSM_MASK),
    .header_els_p(2), .data_els_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fsm_header_i(fsm_header_i), .fsm_has_data_i(fsm_has_data_i), .fsm_data_i(fsm_data_i),
    .fsm_v_i(fsm_v_i), .fsm_ready_and_o(fsm_ready_and_o), .fsm_cnt_o(fsm_cnt_o),
    .fsm_new_o(fsm_new_o), .fsm_last_o(fsm_last_o),
    .msg_header_o(msg_header_o), .msg_header_v_o(msg_header_v_o),
    .msg_header_ready_and_i(msg_header_ready_and_i), .msg_has_data_o(msg_has_data_o),
    .msg_data_o(msg_data_o), .msg_data_v_o(msg_data_v_o),
    .msg_data_ready_and_i(msg_data_ready_and_i), .msg_last_o(msg_last_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats_acc = 0;
  bit hdr_hold = 1'b0, dat_hold = 1'b0, rand_rdy = 1'b0;
  logic [HW:0]  exp_hdr [$];   // {header, has_data}
  logic [SDW:0] exp_dat [$];   // {data, last}

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: beat counts and expected channel contents derived from message attributes.
  task automatic send_msg(input logic [3:0] t, input logic [2:0] sz, input logic [PADDR-1:0] a,
                          input logic hd, input int stop_after, input bit gaps);
    logic [15:0]    fm = FSM_MASK;
    logic [15:0]    mm = MSG_MASK;
    int             bytes = 1 << sz;
    int             words = (bytes / (SDW/8) > 1) ? bytes / (SDW/8) : 1;
    int             n = fm[t] ? words : 1;
    logic [HW-1:0]  hdr;
    logic [SDW-1:0] d [8];
    logic [2:0]     crit = a[5:3];
    hdr = {t, sz, a, PAY'($urandom)};
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    exp_hdr.push_back({hdr, hd});
    if (hd) begin
      if (mm[t]) for (int i = 0; i < n; i++) exp_dat.push_back({d[i], (i == n-1)});
      else       exp_dat.push_back({d[n-1], 1'b1});
    end
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int tmo = 0;
      if (stop_after >= 0 && i >= stop_after) break;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk); fsm_v_i = 1'b0;
      end
      while (!acc && tmo < 300) begin
        @(negedge clk);
        fsm_header_i = hdr; fsm_has_data_i = hd; fsm_data_i = d[i]; fsm_v_i = 1'b1;
        #1;
        chk("fsm_cnt", fsm_cnt_o, (int'(crit) + i) % 8);
        chk("fsm_new", fsm_new_o, (i == 0));
        chk("fsm_last", fsm_last_o, (i == n-1));
        if (fsm_ready_and_o) acc = 1'b1;
        tmo++;
      end
      if (acc) beats_acc++;
      else begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk); fsm_v_i = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while ((exp_hdr.size() != 0 || exp_dat.size() != 0) && tmo < 1000) begin
      @(negedge clk); tmo++;
    end
    chk("drain_hdr_left", exp_hdr.size(), 0);
    chk("drain_dat_left", exp_dat.size(), 0);
  endtask

  // Monitor: drives consumer readies and checks every completed transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      msg_header_ready_and_i = hdr_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      msg_data_ready_and_i   = dat_hold ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      #2;
      if (msg_header_v_o && msg_header_ready_and_i) begin
        if (exp_hdr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hdr_unexpected: got %0h, required no header", msg_header_o);
        end else chk("msg_header", {msg_header_o, msg_has_data_o}, exp_hdr.pop_front());
      end
      if (msg_data_v_o && msg_data_ready_and_i) begin
        if (exp_dat.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dat_unexpected: got %0h, required no data", msg_data_o);
        end else chk("msg_data", {msg_data_o, msg_last_o}, exp_dat.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hdr_v", msg_header_v_o, 0);
    chk("rst_dat_v", msg_data_v_o, 0);
    chk("rst_new", fsm_new_o, 1);
    chk("rst_cnt", fsm_cnt_o, 0);
    @(negedge clk); reset_i = 1'b0;

    // Uncached 8B write, single beat.
    send_msg(4'd0, 3'd3, 40'h1008, 1'b1, -1, 1'b0); idle(); wait_drain();
    // 64B cached write, critical word 3, 1:1.
    send_msg(4'd1, 3'd6, 40'h2018, 1'b1, -1, 1'b0); idle(); wait_drain();
    // 64B read, N:1 with no data.
    send_msg(4'd2, 3'd6, 40'h3000, 1'b0, -1, 1'b0); idle(); wait_drain();

    // Data channel stalled: only the data FIFO depth worth of beats gets in.
    b0 = beats_acc;
    dat_hold = 1'b1;
    fork
      begin send_msg(4'd1, 3'd6, 40'h2018, 1'b1, -1, 1'b0); idle(); end
    join_none
    repeat (10) @(negedge clk);
    #3;
    chk("bp_accepted", beats_acc - b0, 2);
    chk("bp_ready_low", fsm_ready_and_o, 0);
    dat_hold = 1'b0;
    wait fork;
    wait_drain();

    // Reset mid-message discards the partial message.
    send_msg(4'd1, 3'd6, 40'h4028, 1'b1, 3, 1'b0);
    @(negedge clk);
    reset_i = 1'b1; fsm_v_i = 1'b0;
    #1;
    exp_hdr.delete(); exp_dat.delete();
    chk("mid_rst_new", fsm_new_o, 1);
    chk("mid_rst_cnt", fsm_cnt_o, 0);
    @(negedge clk); #1;
    chk("mid_rst_hdr_v", msg_header_v_o, 0);
    chk("mid_rst_dat_v", msg_data_v_o, 0);
    @(negedge clk); reset_i = 1'b0; #1;
    chk("post_rst_hdr_v", msg_header_v_o, 0);
    chk("post_rst_dat_v", msg_data_v_o, 0);
    chk("post_rst_new", fsm_new_o, 1);
    send_msg(4'd0, 3'd3, 40'h5008, 1'b1, -1, 1'b0); idle(); wait_drain();

    // Back-to-back single-beat messages with the header channel stalled briefly.
    hdr_hold = 1'b1;
    fork
      begin
        send_msg(4'd0, 3'd3, 40'h6008, 1'b1, -1, 1'b0);
        send_msg(4'd0, 3'd2, 40'h7010, 1'b1, -1, 1'b0);
        send_msg(4'd0, 3'd3, 40'h8038, 1'b0, -1, 1'b0);
        idle();
      end
    join_none
    repeat (2) @(negedge clk);
    hdr_hold = 1'b0;
    wait fork;
    wait_drain();

    // Randomised traffic with random consumer readiness.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] t = 4'($urandom_range(0, 2));
      logic [2:0] sz = (t == 4'd0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      logic [PADDR-1:0] a = {$urandom, $urandom};
      send_msg(t, sz, a, 1'($urandom), -1, 1'b1);
    end
    idle();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_me_burst_pump_out.md
Name: bp_me_burst_pump_out

Overview:
- Outbound counterpart of the burst pump-in path. A producer FSM (cache engine, CCE or I/O bridge) presents one header plus data beats on a single valid/ready port. The block serialises them into an outbound BedRock Burst interface with separate header and data channels.
- It generates the FSM-side beat count and first/last markers, wraps the count at the critical word within the block, and decouples the two msg channels with small FIFOs.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration (paddr_width_p, lce params).
- stream_data_width_p, none (required), data beat width in bits.
- block_width_p, none (required), cache block width in bits.
- payload_width_p, none (required), BedRock payload width.
- msg_stream_mask_p, 0, bit per msg_type: type is multi-beat on the msg output.
- fsm_stream_mask_p, msg_stream_mask_p, bit per msg_type: type is multi-beat on the FSM input.
- header_els_p, 2, header FIFO depth.
- data_els_p, 2, data FIFO depth.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- fsm_header_i  in  xce_header_width_lp  header; held stable for all beats of a message.
- fsm_has_data_i  in  1  message carries data.
- fsm_data_i  in  stream_data_width_p  beat data.
- fsm_v_i  in  1  beat valid.
- fsm_ready_and_o  out  1  beat accepted when high with fsm_v_i.
- fsm_cnt_o  out  stream_cnt_width_lp  wrapped word index of the current beat.
- fsm_new_o  out  1  current beat is the first of its message.
- fsm_last_o  out  1  current beat is the last of its message.
- msg_header_o  out  xce_header_width_lp  outbound header.
- msg_header_v_o  out  1  header valid.
- msg_header_ready_and_i  in  1  header consumed.
- msg_has_data_o  out  1  sideband travelling with the header.
- msg_data_o  out  stream_data_width_p  outbound data beat.
- msg_data_v_o  out  1  data valid.
- msg_data_ready_and_i  in  1  data consumed.
- msg_last_o  out  1  last data beat of the message.

Behaviour:
- Beat count per message:
  - stream_size = max((1<<size)/stream_bytes_lp, 1) − 1.
  - FSM beats = stream_size+1 if fsm_stream_mask_p[msg_type], else 1.
  - Msg data beats = stream_size+1 if msg_stream_mask_p[msg_type], else 1; 0 if ~has_data.
- Counter:
  - Loads addr[stream_offset+:stream_cnt_width] on the first beat.
  - Increments modulo stream_words_lp on each accepted FSM beat.
  - fsm_new_o is high when the internal beat counter is 0; fsm_last_o is high when it equals (FSM beats − 1).
- States:
  - e_ready: idle, no message in flight.
  - e_stream: mid-message, more FSM beats remain.
  - e_ready→e_stream on an accepted first beat that is not last; e_stream→e_ready on an accepted last beat.
  - A single-beat message stays in e_ready.
- Header path: enqueued into the header FIFO on the accepted new beat. msg_header_o.addr equals the FSM header addr (critical word), unmodified.
- Data enqueue by mode:
  - 1:1 (both masks set, or neither): every accepted data beat enqueues; msg_last_o = fsm_last_o at enqueue.
  - N:1 (fsm set, msg clear): non-last beats are acked without enqueue; the last beat enqueues data with msg_last_o=1.
  - 1:N (msg set, fsm clear): illegal. Assert in simulation; behaviour unspecified.
- fsm_ready_and_o = (~fsm_new_o | header FIFO ready) & (~data_enqueue_this_beat | data FIFO ready).
  - Never depends on fsm_v_i.
- Latency: 1 cycle from FSM accept to msg valid on either channel.
  - Header and data drain independently; data may lead header.
- FIFO full: backpressure only. No beat is dropped and the counter holds.
- Reset: state=e_ready, counter=0, FIFOs empty.
  - Outputs during reset: msg_header_v_o=0, msg_data_v_o=0, fsm_new_o=1, fsm_cnt_o=0.
  - Reset mid-message discards the partial message.
- Parameter errors: block_width_p % stream_data_width_p ≠ 0, or block_width_p < stream_data_width_p.

Optional Feature:
- BP_ME_BURST_PUMP_OUT_CUT_THROUGH_EN
- Defined: when a FIFO is empty, the beat bypasses it combinationally, giving 0-cycle latency. msg_*_v_o may then depend on fsm_v_i.
- Undefined: all msg outputs are FIFO-registered with 1-cycle latency.

Test Plan:
- Uncached 8B write, 64b stream, addr 0x1008: 1 FSM beat → header addr 0x1008, 1 data beat with msg_last=1, fsm_new=fsm_last=1.
- 64B cached write, 512b block, critical addr 0x2018, both masks set: fsm_cnt 3,4,5,6,7,0,1,2; 8 data beats; msg_last only on the 8th; exactly one header.
- 64B read, fsm mask set, msg mask clear, has_data=0: 8 FSM beats accepted, 1 header, 0 data beats.
- Hold msg_data_ready_and_i=0 during the 64B write: fsm_ready_and_o drops after data_els_p enqueues, counter holds; release → all 8 beats delivered in order with no loss.
- Reset asserted after beat 3 of 8: next cycle msg valids=0, fsm_new_o=1; a following 8B message completes normally.
- Back-to-back single-beat messages with the header channel stalled for 2 cycles: headers emerge in order and data is unaffected.
